// File: rtl/tag_alloc_arbiter_if.sv
// Request, grant and free bundle between the requesters and tag_alloc_arbiter.
interface tag_alloc_arbiter_if #(
  parameter int NumTags = 8,
  parameter int NumReq  = 4
);
  localparam int TagWidth = $clog2(NumTags);
  localparam int ReqWidth = $clog2(NumReq);

  logic [NumReq-1:0]   req_valid_i;
  logic [NumReq-1:0]   req_ready_o;
  logic [TagWidth-1:0] gnt_tag_o;
  logic [ReqWidth-1:0] gnt_req_o;
  logic                free_i;
  logic [TagWidth-1:0] free_tag_i;

  modport master (
    output req_valid_i, free_i, free_tag_i,
    input  req_ready_o, gnt_tag_o, gnt_req_o
  );

  modport slave (
    input  req_valid_i, free_i, free_tag_i,
    output req_ready_o, gnt_tag_o, gnt_req_o
  );
endinterface

// File: rtl/tag_alloc_arbiter.sv
// Round-robin tag allocator sharing one tag pool among NumReq requesters, with drain-on-flush.
// Optional feature: define TAG_ALLOC_FREE_CHECK_EN to drop and flag frees of tags not in use.
module tag_alloc_arbiter #(
  parameter int NumTags        = 8,
  parameter int NumReq         = 4,
  parameter int MaxOutstanding = 4,
  parameter int TagWidth       = $clog2(NumTags),
  parameter int ReqWidth       = $clog2(NumReq),
  parameter int CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  tag_alloc_arbiter_if.slave         bus,
  output logic [NumReq*CntWidth-1:0] outstanding_o,
  input  logic                       flush_i,
  output logic                       flush_busy_o,
  output logic                       flush_done_o,
  output logic                       err_o
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e              state_r, state_s;
  logic [NumTags-1:0]  used_r, used_s;
  logic [ReqWidth-1:0] owner_r [NumTags];
  logic [ReqWidth-1:0] owner_s [NumTags];
  logic [CntWidth-1:0] cnt_r   [NumReq];
  logic [CntWidth-1:0] cnt_s   [NumReq];
  logic [ReqWidth-1:0] rr_r, rr_s;

  logic [NumReq-1:0]   elig_s;
  logic                grant_s;
  logic [ReqWidth-1:0] winner_s;
  logic [TagWidth-1:0] alloc_tag_s;
  logic                pool_full_s;
  logic                drained_s;
  logic                free_in_range_s;
  logic                free_apply_s;
  logic [ReqWidth-1:0] free_owner_s;

  // Requester index reached by stepping ofs places past base, wrapping at NumReq.
  function automatic logic [ReqWidth-1:0] rr_index(input logic [ReqWidth-1:0] base, input int ofs);
    int sum;
    sum = int'(base) + ofs;
    if (sum >= NumReq) begin
      sum = sum - NumReq;
    end else begin
      sum = sum;
    end
    return ReqWidth'(sum);
  endfunction

  assign pool_full_s     = &used_r;
  assign drained_s       = ~|used_r;
  assign free_in_range_s = int'(bus.free_tag_i) < NumTags;
  assign free_owner_s    = owner_r[bus.free_tag_i];

`ifdef TAG_ALLOC_FREE_CHECK_EN
  logic err_r;
  logic err_s;

  // A free of a tag nobody holds is discarded and reported.
  assign free_apply_s = bus.free_i && free_in_range_s && used_r[bus.free_tag_i];
  assign err_s        = bus.free_i && !free_apply_s;

  // Error flag register, pulses the cycle after the offending free.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_s;
    end
  end

  assign err_o = !rst_i && err_r;
`else
  assign free_apply_s = bus.free_i && free_in_range_s;
  assign err_o        = 1'b0;
`endif

  // Per-requester eligibility; reset and DRAIN suppress every grant.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NumReq; i++) begin
      elig_s[i] = bus.req_valid_i[i] && (cnt_r[i] < CntWidth'(MaxOutstanding)) &&
                  (state_r == ST_RUN) && !pool_full_s && !rst_i;
    end
  end

  // Round-robin winner: first eligible index at or after rr_r.
  always_comb begin
    grant_s  = 1'b0;
    winner_s = '0;
    for (int k = 0; k < NumReq; k++) begin
      winner_s = (!grant_s && elig_s[rr_index(rr_r, k)]) ? rr_index(rr_r, k) : winner_s;
      grant_s  = grant_s || elig_s[rr_index(rr_r, k)];
    end
  end

  // Lowest-index free tag, from registered occupancy only.
  always_comb begin
    alloc_tag_s = '0;
    for (int t = NumTags - 1; t >= 0; t--) begin
      alloc_tag_s = used_r[t] ? alloc_tag_s : TagWidth'(t);
    end
  end

  // Occupancy and ownership next state; a same-cycle grant and free touch different tags.
  always_comb begin
    used_s = used_r;
    for (int t = 0; t < NumTags; t++) begin
      if (grant_s && (alloc_tag_s == TagWidth'(t))) begin
        used_s[t]  = 1'b1;
        owner_s[t] = winner_s;
      end else if (free_apply_s && (bus.free_tag_i == TagWidth'(t))) begin
        used_s[t]  = 1'b0;
        owner_s[t] = owner_r[t];
      end else begin
        used_s[t]  = used_r[t];
        owner_s[t] = owner_r[t];
      end
    end
  end

  // Outstanding counts; a grant and free for the same requester cancel out.
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      cnt_s[i] = cnt_r[i];
      case ({grant_s && (winner_s == ReqWidth'(i)), free_apply_s && (free_owner_s == ReqWidth'(i))})
        2'b10:   cnt_s[i] = cnt_r[i] + CntWidth'(1);
        2'b01:   cnt_s[i] = (cnt_r[i] == '0) ? '0 : cnt_r[i] - CntWidth'(1);
        default: cnt_s[i] = cnt_r[i];
      endcase
    end
  end

  // Round-robin pointer and flush FSM next state.
  always_comb begin
    rr_s    = rr_r;
    state_s = state_r;
    if (grant_s) begin
      rr_s = (winner_s == ReqWidth'(NumReq - 1)) ? '0 : winner_s + ReqWidth'(1);
    end else begin
      rr_s = rr_r;
    end
    case (state_r)
      ST_RUN:   state_s = flush_i ? ST_DRAIN : ST_RUN;
      ST_DRAIN: state_s = drained_s ? ST_RUN : ST_DRAIN;
      default:  state_s = ST_RUN;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_RUN;
      used_r  <= '0;
      rr_r    <= '0;
      for (int t = 0; t < NumTags; t++) begin
        owner_r[t] <= '0;
      end
      for (int i = 0; i < NumReq; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      state_r <= state_s;
      used_r  <= used_s;
      rr_r    <= rr_s;
      for (int t = 0; t < NumTags; t++) begin
        owner_r[t] <= owner_s[t];
      end
      for (int i = 0; i < NumReq; i++) begin
        cnt_r[i] <= cnt_s[i];
      end
    end
  end

  // Output drive; everything reads zero while reset is asserted.
  always_comb begin
    bus.req_ready_o = '0;
    outstanding_o   = '0;
    for (int i = 0; i < NumReq; i++) begin
      bus.req_ready_o[i] = grant_s && (winner_s == ReqWidth'(i));
      outstanding_o[i*CntWidth +: CntWidth] = rst_i ? '0 : cnt_r[i];
    end
    bus.gnt_tag_o = grant_s ? alloc_tag_s : '0;
    bus.gnt_req_o = grant_s ? winner_s : '0;
    flush_busy_o  = !rst_i && (state_r == ST_DRAIN);
    flush_done_o  = !rst_i && (state_r == ST_DRAIN) && drained_s;
  end

endmodule
